// File: rtl/core_int_arbiter.sv
// rtl/core_int_arbiter.sv - interrupt synchronizer, pending logic and M/S-mode request arbiter
package core_pkg;
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;
endpackage

module core_int_arbiter #(
    parameter int                   NUM_INT     = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [NUM_INT-1:0]   EDGE_MASK   = '0,
    localparam int                  IDW         = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_INT-1:0]      int_src,
    input  logic [NUM_INT-1:0]      int_en,
    input  logic [NUM_INT-1:0]      int_deleg,
    input  logic [NUM_INT-1:0]      int_clear,
    input  core_pkg::priv_e         priv,
    input  logic                    cfg_mie,
    input  logic                    cfg_sie,
    input  logic                    check_interrupt,
    input  logic                    int_ack,
    output logic [NUM_INT-1:0]      int_pending,
    output logic                    int_valid,
    output logic                    int_target_s,
    output logic [IDW-1:0]          int_id
);
    import core_pkg::*;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

    logic [NUM_INT-1:0] s;
    logic [NUM_INT-1:0] s_prev;
    logic [NUM_INT-1:0] edge_q;
    logic [NUM_INT-1:0] pending;
    logic [NUM_INT-1:0] ack_clr;
    logic [NUM_INT-1:0] m_cand;
    logic [NUM_INT-1:0] s_cand;
    logic               m_en;
    logic               s_en;
    logic               m_found;
    logic               s_found;
    logic [IDW-1:0]     m_idx;
    logic [IDW-1:0]     s_idx;
    logic               still_cand;
    logic               ack_fire;
    state_e             state_q, state_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               tgt_q, tgt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = int_src;
        end else begin : g_sync
            logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= int_src;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign ack_fire = (state_q == REQ) && int_ack;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_INT; i++) ack_clr[i] = ack_fire && (id_q == IDW'(i));
    end

    // A rising edge in the same cycle as a clear wins, so no edge is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= '0;
            edge_q <= '0;
        end else begin
            s_prev <= s;
            edge_q <= ((edge_q & ~(int_clear | ack_clr)) | (s & ~s_prev)) & EDGE_MASK;
        end
    end

    assign pending     = (EDGE_MASK & edge_q) | (~EDGE_MASK & s);
    assign int_pending = pending;

    assign m_en   = (priv != PRIV_M) || cfg_mie;
    assign s_en   = (priv == PRIV_U) || ((priv == PRIV_S) && cfg_sie);
    assign m_cand = pending & int_en & ~int_deleg & {NUM_INT{m_en}};
    assign s_cand = pending & int_en &  int_deleg & {NUM_INT{s_en}};

    // Descending scan leaves the lowest set index as the winner.
    always_comb begin
        m_found = 1'b0;
        s_found = 1'b0;
        m_idx   = '0;
        s_idx   = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (m_cand[i]) begin
                m_found = 1'b1;
                m_idx   = IDW'(i);
            end
            if (s_cand[i]) begin
                s_found = 1'b1;
                s_idx   = IDW'(i);
            end
        end
    end

    assign still_cand = tgt_q ? s_cand[id_q] : m_cand[id_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (check_interrupt && (m_found || s_found)) begin
                    state_d = REQ;
                    id_d    = m_found ? m_idx : s_idx;
                    tgt_d   = !m_found;
                end
            end
            REQ: begin
                if (int_ack)          state_d = ACK;
                else if (!still_cand) state_d = IDLE;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign int_valid    = (state_q == REQ);
    assign int_id       = id_q;
    assign int_target_s = tgt_q;
endmodule

// File: tb/tb_core_int_arbiter.sv
// tb/tb_core_int_arbiter.sv - directed self-checking bench for core_int_arbiter
module tb_core_int_arbiter;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          int_src = '0;
    logic [7:0]          int_en = '0;
    logic [7:0]          int_deleg = '0;
    logic [7:0]          int_clear = '0;
    core_pkg::priv_e     priv = core_pkg::PRIV_U;
    logic                cfg_mie = 1'b0;
    logic                cfg_sie = 1'b0;
    logic                check_interrupt = 1'b0;
    logic                int_ack = 1'b0;
    logic [7:0]          int_pending;
    logic                int_valid;
    logic                int_target_s;
    logic [2:0]          int_id;

    int n_cmp = 0;
    int n_bad = 0;

    core_int_arbiter #(
        .NUM_INT     (8),
        .SYNC_STAGES (2),
        .EDGE_MASK   (8'h20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .int_src         (int_src),
        .int_en          (int_en),
        .int_deleg       (int_deleg),
        .int_clear       (int_clear),
        .priv            (priv),
        .cfg_mie         (cfg_mie),
        .cfg_sie         (cfg_sie),
        .check_interrupt (check_interrupt),
        .int_ack         (int_ack),
        .int_pending     (int_pending),
        .int_valid       (int_valid),
        .int_target_s    (int_target_s),
        .int_id          (int_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_valid", int_valid, 0);
        check("rst_id", int_id, 0);
        check("rst_tgt", int_target_s, 0);
        check("rst_pend", int_pending, 8'h00);
        tick(1);
        rst_n = 1'b1;
        int_en = 8'hFF;
        check_interrupt = 1'b1;
        tick(2);

        // level source 3: valid three cycles after the source rises
        int_src = 8'h08;
        tick(2);
        check("lvl_pend", int_pending, 8'h08);
        check("lvl_valid_early", int_valid, 0);
        tick(1);
        check("lvl_valid", int_valid, 1);
        check("lvl_id", int_id, 3);
        check("lvl_tgt", int_target_s, 0);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("ack_state", int_valid, 0);
        tick(1);
        check("ack_idle", int_valid, 0);
        tick(1);
        check("rereq", int_valid, 1);

        // withdraw: frozen source 3 drops, source 7 stays -> IDLE then REQ id 7
        int_src = 8'h88;
        tick(2);
        check("frozen_id", int_id, 3);
        int_src = 8'h80;
        tick(2);
        check("pre_wd_valid", int_valid, 1);
        tick(1);
        check("wd_valid", int_valid, 0);
        tick(1);
        check("wd_rereq", int_valid, 1);
        check("wd_id", int_id, 7);

        // frozen source 7 drops together with ack -> ACK wins (one extra idle cycle)
        int_src = 8'h88;
        tick(2);
        int_src = 8'h08;
        tick(2);
        check("pre_ack_valid", int_valid, 1);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("dack_valid0", int_valid, 0);
        tick(1);
        check("dack_valid1", int_valid, 0);
        tick(1);
        check("dack_rereq", int_valid, 1);
        check("dack_id", int_id, 3);
        int_src = 8'h00;
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tick(2);
        check("quiet", int_valid, 0);

        // edge source 5
        int_src = 8'h20;
        tick(1);
        int_src = 8'h00;
        tick(2);
        check("edge_latch", int_pending, 8'h20);
        tick(1);
        check("edge_valid", int_valid, 1);
        check("edge_id", int_id, 5);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("edge_ack_clr", int_pending, 8'h00);
        tick(2);
        check("edge_no_rereq", int_valid, 0);

        check_interrupt = 1'b0;
        int_src = 8'h20;
        tick(1);
        int_src = 8'h00;
        tick(4);
        check("edge_hold", int_pending, 8'h20);
        check("nocheck_valid", int_valid, 0);
        int_clear = 8'h20;
        tick(1);
        int_clear = 8'h00;
        check("edge_clear", int_pending, 8'h00);
        int_src = 8'h20;
        tick(1);
        int_src = 8'h00;
        tick(3);
        int_src = 8'h20;
        tick(1);
        int_src = 8'h00;
        tick(1);
        int_clear = 8'h20;
        tick(1);
        int_clear = 8'h00;
        check("set_beats_clr", int_pending, 8'h20);
        int_clear = 8'h20;
        tick(1);
        int_clear = 8'h00;
        check("edge_clear2", int_pending, 8'h00);

        // delegation and privilege gating
        check_interrupt = 1'b1;
        int_deleg = 8'h02;
        priv = core_pkg::PRIV_S;
        cfg_sie = 1'b1;
        int_src = 8'h42;
        tick(3);
        check("m_beats_s_valid", int_valid, 1);
        check("m_beats_s_id", int_id, 6);
        check("m_beats_s_tgt", int_target_s, 0);
        int_src = 8'h02;
        tick(4);
        check("s_valid", int_valid, 1);
        check("s_id", int_id, 1);
        check("s_tgt", int_target_s, 1);
        priv = core_pkg::PRIV_M;
        cfg_mie = 1'b0;
        int_src = 8'h42;
        tick(3);
        check("m_mode_block", int_valid, 0);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tick(1);
        check("ack_ignored", int_valid, 0);
        cfg_mie = 1'b1;
        tick(1);
        check("m_mie_valid", int_valid, 1);
        check("m_mie_id", int_id, 6);
        int_src = 8'h00;
        tick(4);
        check("m_quiet", int_valid, 0);

        // asynchronous reset while in REQ with an edge bit pending
        int_deleg = 8'h00;
        int_src = 8'h20;
        tick(1);
        int_src = 8'h00;
        tick(3);
        check("prerst_valid", int_valid, 1);
        check("prerst_id", int_id, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int_valid, 0);
        check("arst_id", int_id, 0);
        check("arst_pend", int_pending, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_valid", int_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_int_arbiter.md
CORE_INT_ARBITER -- requirements
Module: core_int_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_INT, default 8, meaning the number of interrupt sources (legal range 1..32).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops per source (legal range 0..3; 0 means no synchronizer).
REQ-003 The module SHALL have parameter EDGE_MASK, default '0, NUM_INT bits wide; bit i=1 makes source i edge-triggered (rising), bit i=0 makes it level-triggered.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 Port list, one per line (name  direction  width  meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- int_src  in  NUM_INT  raw interrupt lines.
- int_en  in  NUM_INT  per-source enable (mie view).
- int_deleg  in  NUM_INT  1 = source delegated to S-mode.
- int_clear  in  NUM_INT  clears the edge-pending bit of source i.
- priv  in  core_pkg::priv_e  current privilege.
- cfg_mie  in  1  mstatus.MIE.
- cfg_sie  in  1  mstatus.SIE.
- check_interrupt  in  1  controller is at an interruptible boundary.
- int_ack  in  1  controller takes the presented interrupt.
- int_pending  out  NUM_INT  pending bits (mip view).
- int_valid  out  1  interrupt request presented.
- int_target_s  out  1  1 = request targets S-mode, 0 = M-mode.
- int_id  out  IDW  presented source index, where IDW = max(1, $clog2(NUM_INT)).

Function
REQ-006 Each int_src bit SHALL pass through SYNC_STAGES flops before use; the synchronized value is s[i].
REQ-007 For a level source, pending[i] SHALL equal s[i] combinationally (no storage).
REQ-008 For an edge source, pending[i] SHALL be a flop set on a cycle with s[i]=1 while s[i] was 0 in the previous cycle, and cleared by int_clear[i] or by acknowledge (REQ-015); a set and a clear in the same cycle SHALL leave the bit set.
REQ-009 int_pending SHALL equal pending, exposed directly.
REQ-010 Source i SHALL be an M-candidate when pending[i] & int_en[i] & ~int_deleg[i] and M-enable holds, where M-enable = (priv != PRIV_M) | cfg_mie.
REQ-011 Source i SHALL be an S-candidate when pending[i] & int_en[i] & int_deleg[i] and S-enable holds, where S-enable = (priv == PRIV_U) | (priv == PRIV_S & cfg_sie); S-enable SHALL be 0 in PRIV_M.
REQ-012 Selection: any M-candidate SHALL beat any S-candidate; within a target, the lowest index SHALL win.
REQ-013 The FSM SHALL have states IDLE, REQ and ACK, with reset state IDLE.
REQ-014 IDLE -> REQ SHALL occur when check_interrupt=1 and a candidate exists; the winner's index and target SHALL be registered into int_id and int_target_s on that edge.
REQ-015 In REQ, int_valid=1 and int_id/int_target_s SHALL be frozen; int_ack=1 SHALL move the FSM to ACK and, if the frozen source is edge-triggered, clear its pending bit on the same edge.
REQ-016 In REQ, if the frozen source is no longer a candidate and int_ack=0, the FSM SHALL return to IDLE (withdraw); an int_ack in the same cycle SHALL take precedence and go to ACK.
REQ-017 ACK SHALL last exactly one cycle with int_valid=0, then go to IDLE; a new request SHALL be possible no earlier than the cycle after IDLE is re-entered.
REQ-018 int_valid SHALL be asserted only in REQ; latency from synchronized pending to int_valid SHALL be 1 cycle, given check_interrupt=1.
REQ-019 int_ack while not in REQ SHALL be ignored.

Reset
REQ-020 While rst_n=0: synchronizer flops=0, edge-pending flops=0, state=IDLE, int_valid=0, int_target_s=0, int_id=0; level-source int_pending bits SHALL follow s (0 after the synchronizers are flushed).
REQ-021 Reset asserted in REQ or ACK SHALL return the FSM to IDLE immediately, with no acknowledge side effects.

Verification
REQ-022 NUM_INT=8, SYNC_STAGES=2, level src[3]=1, en=8'hFF, deleg=0, priv=U, check=1 -> int_valid rises 3 cycles after src, id=3, target_s=0; ack -> ACK for 1 cycle, then REQ again (level still high).
REQ-023 Edge src[5] pulses for 1 cycle -> pending[5] latches; ack -> pending[5]=0; int_clear[5] asserted in the same cycle as a new rising edge -> pending[5] stays 1.
REQ-024 src[1] (deleg=1) and src[6] (deleg=0) pending together with priv=S, cfg_sie=1 -> id=6, target_s=0; priv=M, cfg_mie=0 -> no request.
REQ-025 In REQ, level source deasserts without ack -> withdraw to IDLE, int_valid=0 next cycle; deassert plus ack in the same cycle -> ACK.
REQ-026 rst_n pulled low in REQ -> int_valid=0 and int_id=0 asynchronously; edge-pending flops cleared.
